// File: rtl/apb_timer_multi.sv
// NUM_CH independent WIDTH-bit up/down timers behind one APB slave with a single wait state.
// Shared 4-bit prescaler, per-channel auto-reload, W1C overflow/underflow flags and level irq.
module apb_timer_multi #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 2
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [7:0]        paddr,
  input  logic [WIDTH-1:0]  pwdata,
  output logic [WIDTH-1:0]  prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [NUM_CH-1:0] irq
);

  logic [3:0]        pcnt_q, pcnt_d;
  logic [3:0]        tick;
  logic [WIDTH-1:0]  tdr_q  [NUM_CH];
  logic [WIDTH-1:0]  tdr_d  [NUM_CH];
  logic [WIDTH-1:0]  tcnt_q [NUM_CH];
  logic [WIDTH-1:0]  tcnt_d [NUM_CH];
  logic [7:0]        tcr_q  [NUM_CH];
  logic [7:0]        tcr_d  [NUM_CH];
  logic [NUM_CH-1:0] ovf_q, ovf_d, udf_q, udf_d, irq_q, irq_d;
  logic              pready_q, pready_d, pslverr_q, pslverr_d;
  logic [WIDTH-1:0]  prdata_q, prdata_d, rd_mux;
  logic [5:0]        ch_idx;
  logic [1:0]        off;
  logic              acc, oob, commit;

  assign ch_idx = paddr[7:2];
  assign off    = paddr[1:0];
  assign acc    = psel & penable;
  assign oob    = (int'(ch_idx) >= NUM_CH);
  // Writes land on the edge that ends the pready=1 access cycle.
  assign commit = acc & pready_q & pwrite & ~oob;
  assign tick   = {&pcnt_q[3:0], &pcnt_q[2:0], &pcnt_q[1:0], pcnt_q[0]};

  always_comb begin
    pcnt_d = pcnt_q + 4'd1;
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      tdr_d[i]  = tdr_q[i];
      tcr_d[i]  = tcr_q[i];
      tcnt_d[i] = tcnt_q[i];
      ovf_d[i]  = ovf_q[i];
      udf_d[i]  = udf_q[i];
      irq_d[i]  = (ovf_q[i] & tcr_q[i][3]) | (udf_q[i] & tcr_q[i][2]);

      // Software clear is applied first so a same-cycle hardware set overrides it.
      if (commit && (ch_idx == 6'(i))) begin
        case (off)
          2'd0:    tdr_d[i] = pwdata;
          2'd1:    tcr_d[i] = pwdata[7:0];
          2'd2: begin
            if (pwdata[0]) ovf_d[i] = 1'b0;
            if (pwdata[1]) udf_d[i] = 1'b0;
          end
          default: ;
        endcase
      end

      if (tcr_q[i][7]) begin
        tcnt_d[i] = tdr_q[i];
      end else if (tcr_q[i][4] && tick[tcr_q[i][1:0]]) begin
        if (tcr_q[i][5]) begin
          if (tcnt_q[i] == '0) begin
            tcnt_d[i] = tcr_q[i][6] ? tdr_q[i] : '1;
            udf_d[i]  = 1'b1;
          end else begin
            tcnt_d[i] = tcnt_q[i] - WIDTH'(1);
          end
        end else begin
          if (&tcnt_q[i]) begin
            tcnt_d[i] = tcr_q[i][6] ? tdr_q[i] : '0;
            ovf_d[i]  = 1'b1;
          end else begin
            tcnt_d[i] = tcnt_q[i] + WIDTH'(1);
          end
        end
      end

      if (ch_idx == 6'(i)) begin
        case (off)
          2'd0:    rd_mux = tdr_q[i];
          2'd1:    rd_mux = WIDTH'(tcr_q[i]);
          2'd2:    rd_mux = WIDTH'({udf_q[i], ovf_q[i]});
          default: rd_mux = tcnt_q[i];
        endcase
      end
    end

    // Response is prepared during the first access cycle and presented in the second.
    pready_d  = acc & ~pready_q;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    if (acc && !pready_q) begin
      pslverr_d = oob | (pwrite & (off == 2'd3));
      if (!pwrite && !oob) prdata_d = rd_mux;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      pcnt_q    <= '0;
      ovf_q     <= '0;
      udf_q     <= '0;
      irq_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        tdr_q[i]  <= '0;
        tcr_q[i]  <= '0;
        tcnt_q[i] <= '0;
      end
    end else begin
      pcnt_q    <= pcnt_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      irq_q     <= irq_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      for (int i = 0; i < NUM_CH; i++) begin
        tdr_q[i]  <= tdr_d[i];
        tcr_q[i]  <= tcr_d[i];
        tcnt_q[i] <= tcnt_d[i];
      end
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign irq     = irq_q;

endmodule
